// File: rtl/int_req_ctrl.sv
// ---------------------------------------------------------------------------
// int_req_ctrl
// Interrupt request controller feeding the CPU wrapper's int_sig input.
// Rising edges on src_irq latch as pending requests. The lowest-index
// pending and enabled source is granted with a single-cycle int_sig pulse.
// The controller then stays in service until the CPU pulses int_done.
//
// Build option:
//   INT_SYNC_EN  - when defined, each src_irq bit passes through a 2-flop
//                  synchronizer before edge detection. This adds 2 cycles of
//                  request latency and is required for asynchronous pad
//                  inputs. When undefined, src_irq must already be
//                  synchronous to clk.
// ---------------------------------------------------------------------------
module int_req_ctrl #(
  parameter int unsigned          NUM_SRC  = 4,
  parameter logic [NUM_SRC-1:0]   MASK_RST = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               lost_clr,
  input  logic               int_done,
  output logic               int_sig,
  output logic [2:0]         int_id,
  output logic               busy,
  output logic [NUM_SRC-1:0] pending,
  output logic               lost_flag
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_e;

  state_e               state_q;
  logic                 int_sig_q;
  logic                 busy_q;
  logic [2:0]           int_id_q;

  logic [NUM_SRC-1:0]   src_det;    // source view seen by the edge detector
  logic [NUM_SRC-1:0]   src_q;      // previous src_det, for edge detection
  logic [NUM_SRC-1:0]   src_rise;

  logic [NUM_SRC-1:0]   mask_q,    mask_d;
  logic [NUM_SRC-1:0]   pending_q, pending_d;
  logic                 lost_q,    lost_d;

  logic [NUM_SRC-1:0]   eligible;
  logic [NUM_SRC-1:0]   lowest_onehot;
  logic [NUM_SRC-1:0]   grant_clr;
  logic                 grant_vld;
  logic [2:0]           winner_idx;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
`ifdef INT_SYNC_EN
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;

  // Two-flop synchronizer, one chain per source bit.
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples the pre-edge value and the chain really is two stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_irq;
      sync2_q <= sync1_q;
    end
  end

  assign src_det = sync2_q;
`else
  assign src_det = src_irq;
`endif

  // Remember the previous level so that only low->high transitions count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
    end else begin
      src_q <= src_det;
    end
  end

  assign src_rise = src_det & ~src_q;

  // -------------------------------------------------------------------------
  // Arbitration: lowest enabled pending index wins, only while idle
  // -------------------------------------------------------------------------
  assign eligible      = pending_q & mask_q;
  // The two's-complement trick isolates the lowest set bit of eligible.
  assign lowest_onehot = eligible & (~eligible + 1'b1);
  assign grant_vld     = (state_q == S_IDLE) && (|eligible);
  assign grant_clr     = grant_vld ? lowest_onehot : '0;

  // Encode the winning index for int_id; the upper bits stay 0 for narrow builds.
  // NOTE: assign a default before the loop so that every path drives
  // winner_idx and no latch is inferred.
  always_comb begin
    winner_idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner_idx = 3'(i);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pending, lost and mask next-state
  // -------------------------------------------------------------------------
  // A new edge overrides the grant clear, so a request that arrives during
  // its own grant is not lost. The lost flag only records edges that land on
  // a bit that stays pending, and a new loss wins over lost_clr.
  always_comb begin
    pending_d = (pending_q & ~grant_clr) | src_rise;
    lost_d    = (lost_q & ~lost_clr) | (|(src_rise & pending_q & ~grant_clr));
    mask_d    = mask_we ? mask_wdata : mask_q;
  end

  // Register pending requests, the sticky lost flag and the enable mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      lost_q    <= 1'b0;
      mask_q    <= MASK_RST;
    end else begin
      pending_q <= pending_d;
      lost_q    <= lost_d;
      mask_q    <= mask_d;
    end
  end

  // -------------------------------------------------------------------------
  // Grant / service FSM with registered outputs
  // -------------------------------------------------------------------------
  // IDLE grants and moves to REQ. REQ drives the single int_sig cycle.
  // SERVICE holds busy until the CPU returns with int_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      int_sig_q <= 1'b0;
      busy_q    <= 1'b0;
      int_id_q  <= 3'd0;
    end else begin
      int_sig_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            state_q   <= S_REQ;
            int_sig_q <= 1'b1;
            busy_q    <= 1'b1;
            int_id_q  <= winner_idx;
          end
        end
        S_REQ: begin
          state_q <= S_SERVICE;
        end
        S_SERVICE: begin
          if (int_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign int_sig   = int_sig_q;
  assign int_id    = int_id_q;
  assign busy      = busy_q;
  assign pending   = pending_q;
  assign lost_flag = lost_q;

  // -------------------------------------------------------------------------
  // Protocol invariants
  // -------------------------------------------------------------------------
  a_sig_implies_busy : assert property (@(posedge clk) disable iff (rst)
    int_sig |-> busy);
  a_sig_single_cycle : assert property (@(posedge clk) disable iff (rst)
    int_sig |=> !int_sig);
  a_grant_onehot     : assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant_clr));

endmodule

// File: tb/tb_int_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_int_req_ctrl
// Self-checking bench for int_req_ctrl. It runs these phases in order:
// - a directed vector table
// - hand sequences for async reset, held lines and request latency
// - random stimulus compared against a behavioural model
// ---------------------------------------------------------------------------
module tb_int_req_ctrl;

  localparam int NS = 4;
`ifdef INT_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NS-1:0] src_irq;
  logic          mask_we;
  logic [NS-1:0] mask_wdata;
  logic          lost_clr;
  logic          int_done;
  logic          int_sig;
  logic [2:0]    int_id;
  logic          busy;
  logic [NS-1:0] pending;
  logic          lost_flag;

  int n_tests = 0;
  int n_fail  = 0;

  int_req_ctrl #(.NUM_SRC(NS), .MASK_RST(4'hF)) dut (
    .clk        (clk),
    .rst        (rst),
    .src_irq    (src_irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .lost_clr   (lost_clr),
    .int_done   (int_done),
    .int_sig    (int_sig),
    .int_id     (int_id),
    .busy       (busy),
    .pending    (pending),
    .lost_flag  (lost_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NS-1:0] src;
    logic          mwe;
    logic [NS-1:0] mwd;
    logic          lclr;
    logic          done;
    logic          e_sig;
    logic [2:0]    e_id;
    logic          e_busy;
    logic [NS-1:0] e_pend;
    logic          e_lost;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [NS-1:0] src, input logic mwe, input logic [NS-1:0] mwd,
                     input logic lclr, input logic done, input logic e_sig,
                     input logic [2:0] e_id, input logic e_busy,
                     input logic [NS-1:0] e_pend, input logic e_lost);
    vec_t v;
    v.src = src; v.mwe = mwe; v.mwd = mwd; v.lclr = lclr; v.done = done;
    v.e_sig = e_sig; v.e_id = e_id; v.e_busy = e_busy; v.e_pend = e_pend; v.e_lost = e_lost;
    vq.push_back(v);
  endtask

  // ---------------- behavioural model ----------------
  // Phase 0 = idle, 1 = pulsing int_sig, 2 = waiting for the CPU to return.
  logic [NS-1:0] m_pend, m_mask, m_prev;
  logic [NS-1:0] m_dly[2];
  logic          m_lost;
  logic [2:0]    m_id;
  int            m_phase;

  task automatic model_reset();
    m_pend = '0; m_mask = 4'hF; m_prev = '0; m_lost = 1'b0; m_id = 3'd0; m_phase = 0;
    m_dly[0] = '0; m_dly[1] = '0;
  endtask

  // Called exactly at a rising clock edge with the inputs present there.
  task automatic model_step();
    logic [NS-1:0] seen, rise, taken;
    int win;
`ifdef INT_SYNC_EN
    seen = m_dly[1];
    m_dly[1] = m_dly[0];
    m_dly[0] = src_irq;
`else
    seen = src_irq;
`endif
    rise   = seen & ~m_prev;
    m_prev = seen;
    taken  = '0;
    win    = -1;
    if (m_phase == 0) begin
      for (int i = 0; i < NS; i++) begin
        if (win < 0 && m_pend[i] && m_mask[i]) win = i;
      end
    end
    case (m_phase)
      0: if (win >= 0) begin m_phase = 1; m_id = 3'(win); taken[win] = 1'b1; end
      1: m_phase = 2;
      default: if (int_done) m_phase = 0;
    endcase
    if (lost_clr) m_lost = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (rise[i] && m_pend[i] && !taken[i]) m_lost = 1'b1;
    end
    for (int i = 0; i < NS; i++) begin
      if (taken[i]) m_pend[i] = 1'b0;
      if (rise[i])  m_pend[i] = 1'b1;
    end
    if (mask_we) m_mask = mask_wdata;
  endtask

  task automatic drive_idle();
    src_irq = '0; mask_we = 1'b0; mask_wdata = '0; lost_clr = 1'b0; int_done = 1'b0;
  endtask

  // Reset held across two edges and released one time unit after an edge.
  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int cnt, first, waited;

    rst = 1'b1;
    drive_idle();
    model_reset();
    #12;
    check("reset int_sig", int_sig, 0);
    check("reset int_id", int_id, 0);
    check("reset busy", busy, 0);
    check("reset pending", pending, 0);
    check("reset lost", lost_flag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifndef INT_SYNC_EN
    //   src      mwe  mwd      clr  done  sig id  busy pend     lost
    add(4'b0100, 0, 4'b0000, 0, 0,   0, 0, 0, 4'b0100, 0); // single request
    add(4'b0100, 0, 4'b0000, 0, 0,   1, 2, 1, 4'b0000, 0);
    add(4'b0100, 0, 4'b0000, 0, 0,   0, 2, 1, 4'b0000, 0);
    add(4'b0100, 0, 4'b0000, 0, 1,   0, 2, 0, 4'b0000, 0); // held line, no re-request
    add(4'b0000, 0, 4'b0000, 0, 0,   0, 2, 0, 4'b0000, 0);
    add(4'b1010, 0, 4'b0000, 0, 0,   0, 2, 0, 4'b1010, 0); // priority
    add(4'b1010, 0, 4'b0000, 0, 0,   1, 1, 1, 4'b1000, 0);
    add(4'b0000, 0, 4'b0000, 0, 0,   0, 1, 1, 4'b1000, 0);
    add(4'b0000, 0, 4'b0000, 0, 1,   0, 1, 0, 4'b1000, 0);
    add(4'b0000, 0, 4'b0000, 0, 0,   1, 3, 1, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 0,   0, 3, 1, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 1,   0, 3, 0, 4'b0000, 0);
    add(4'b0000, 1, 4'b1110, 0, 0,   0, 3, 0, 4'b0000, 0); // masking
    add(4'b0001, 0, 4'b0000, 0, 0,   0, 3, 0, 4'b0001, 0);
    add(4'b0001, 0, 4'b0000, 0, 0,   0, 3, 0, 4'b0001, 0);
    add(4'b0001, 1, 4'b1111, 0, 0,   0, 3, 0, 4'b0001, 0);
    add(4'b0001, 0, 4'b0000, 0, 0,   1, 0, 1, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 0,   0, 0, 1, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 1,   0, 0, 0, 4'b0000, 0);
    add(4'b0010, 0, 4'b0000, 0, 0,   0, 0, 0, 4'b0010, 0); // lost / set-wins
    add(4'b0000, 0, 4'b0000, 0, 0,   1, 1, 1, 4'b0000, 0);
    add(4'b0010, 0, 4'b0000, 0, 0,   0, 1, 1, 4'b0010, 0);
    add(4'b0000, 0, 4'b0000, 0, 0,   0, 1, 1, 4'b0010, 0);
    add(4'b0010, 0, 4'b0000, 0, 0,   0, 1, 1, 4'b0010, 1);
    add(4'b0000, 0, 4'b0000, 0, 1,   0, 1, 0, 4'b0010, 1);
    add(4'b0010, 0, 4'b0000, 0, 0,   1, 1, 1, 4'b0010, 1); // edge on grant: stays pending
    add(4'b0000, 0, 4'b0000, 1, 0,   0, 1, 1, 4'b0010, 0);
    add(4'b0000, 0, 4'b0000, 0, 1,   0, 1, 0, 4'b0010, 0);
    add(4'b0000, 0, 4'b0000, 0, 0,   1, 1, 1, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 0,   0, 1, 1, 4'b0000, 0);
    add(4'b0000, 0, 4'b0000, 0, 1,   0, 1, 0, 4'b0000, 0);

    for (int i = 0; i < vq.size(); i++) begin
      src_irq = vq[i].src; mask_we = vq[i].mwe; mask_wdata = vq[i].mwd;
      lost_clr = vq[i].lclr; int_done = vq[i].done;
      @(posedge clk);
      #1;
      check($sformatf("row%0d int_sig", i), int_sig, vq[i].e_sig);
      check($sformatf("row%0d int_id", i), int_id, vq[i].e_id);
      check($sformatf("row%0d busy", i), busy, vq[i].e_busy);
      check($sformatf("row%0d pending", i), pending, vq[i].e_pend);
      check($sformatf("row%0d lost", i), lost_flag, vq[i].e_lost);
    end
`endif

    // ---------------- async reset in the middle of service ----------------
    do_reset();
    src_irq = 4'b0100;
    waited = 0;
    while (!busy && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("pre-reset busy", busy, 1);
    src_irq = 4'b0010;            // leave a fresh request pending as well
    @(posedge clk);
    #3;
    rst = 1'b1;
    src_irq = '0;
    #1;                           // no clock edge between rst and the samples
    check("async rst int_sig", int_sig, 0);
    check("async rst int_id", int_id, 0);
    check("async rst busy", busy, 0);
    check("async rst pending", pending, 0);
    check("async rst lost", lost_flag, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // The reset mask must enable source 3.
    src_irq = 4'b1000;
    waited = 0;
    while (!int_sig && waited < 10) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("post-reset grant sig", int_sig, 1);
    check("post-reset grant id", int_id, 3);

    // ---------------- held line and request latency ----------------
    do_reset();
    src_irq  = 4'b0001;
    int_done = 1'b1;              // ignored outside SERVICE
    cnt = 0;
    first = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (int_sig) begin
        cnt++;
        if (first == 0) first = c;
      end
    end
    check("held line pulses", cnt, 1);
    check("request latency", first, LAT);
    check("held line id", int_id, 0);

    // ---------------- random run against the model ----------------
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int b = 0; b < NS; b++) begin
        if ($urandom_range(0, 3) == 0) src_irq[b] = ~src_irq[b];
      end
      int_done   = ($urandom_range(0, 3) == 0);
      mask_we    = ($urandom_range(0, 15) == 0);
      mask_wdata = NS'($urandom_range(0, 15));
      lost_clr   = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      model_step();
      #1;
      check("rand int_sig", int_sig, (m_phase == 1));
      check("rand busy", busy, (m_phase != 0));
      check("rand int_id", int_id, m_id);
      check("rand pending", pending, m_pend);
      check("rand lost", lost_flag, m_lost);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
